// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and bit-timing helpers for the UART receive controller
//
// Purpose:
//   Holds the baud and parity code points, the frame-supervision FSM encoding,
//   and the functions that turn a baud code into bit-period clock cycles and
//   classify a received byte against its parity bit.
package uart_pkg;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_ODD      = 2'b01;
  localparam logic [1:0] PAR_EVEN     = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_FRAME     = 2'b01,
    ST_STOP_WAIT = 2'b10
  } rx_state_t;

  function automatic int unsigned baud_hz(input logic [1:0] code);
    case (code)
      BAUD_2400: return 2400;
      BAUD_4800: return 4800;
      BAUD_9600: return 9600;
      default:   return 19200;
    endcase
  endfunction

  // Rounded to the nearest whole cycle.
  function automatic int unsigned bit_period_cycles(input logic [1:0] code,
                                                    input int unsigned clk_freq);
    int unsigned rate;
    rate = baud_hz(code);
    return (clk_freq + rate / 2) / rate;
  endfunction

  function automatic logic parity_error(input logic [1:0] ptype,
                                        input logic [DATA_W-1:0] data,
                                        input logic pbit);
    case (ptype)
      PAR_EVEN: return (^data) != pbit;
      PAR_ODD:  return (~^data) != pbit;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous FIFO holding received bytes with their error tag
//
// Purpose:
//   Small power-of-two FIFO. A push while full is accepted only when a pop
//   happens in the same cycle; a pop while empty is ignored.
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_push, i_data      write request and entry
//   i_pop               read request (head advances)
//   o_data              current head entry
//   o_full, o_empty     occupancy flags
//   o_count             current number of entries
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A slot freed by a same-cycle pop can take the incoming entry.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver sequencer: config staging, frame supervision, parity tagging, receive queue
//
// Purpose:
//   Owns the receiver's baud/parity configuration and only swaps in host
//   writes between frames, watches the serial line for frame starts, times
//   out frames that never complete, and queues each received byte with its
//   parity-error tag for a valid/ready consumer.
// Ports:
//   i_clk, i_reset                      clock, asynchronous active-high reset
//   i_cfg_wr, i_cfg_baud_rate,
//   i_cfg_parity_type                   host configuration write
//   i_din                               serial line (asynchronous)
//   i_uart_recieve_flag, i_uart_out,
//   i_uart_parity_bit                   receiver byte-done flag, byte, parity bit
//   o_baud_rate, o_parity_type          active configuration to the receiver
//   o_cfg_pending                       a written configuration awaits application
//   o_busy                              a frame is in progress or its stop is pending
//   o_m_data, o_m_perr, o_m_valid,
//   i_m_ready                           receive queue head, valid/ready handshake
//   o_fifo_count                        queue occupancy
//   o_overflow, o_timeout_err, i_clr_err sticky error flags and their clear
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned TIMEOUT_BITS = 12,
  parameter logic [1:0]  RESET_BAUD   = 2'b11,
  parameter logic [1:0]  RESET_PARITY = 2'b10
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_cfg_wr,
  input  logic [1:0]                    i_cfg_baud_rate,
  input  logic [1:0]                    i_cfg_parity_type,
  input  logic                          i_din,
  input  logic                          i_uart_recieve_flag,
  input  logic [7:0]                    i_uart_out,
  input  logic                          i_uart_parity_bit,
  output logic [1:0]                    o_baud_rate,
  output logic [1:0]                    o_parity_type,
  output logic                          o_cfg_pending,
  output logic                          o_busy,
  output logic [7:0]                    o_m_data,
  output logic                          o_m_perr,
  output logic                          o_m_valid,
  input  logic                          i_m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overflow,
  output logic                          o_timeout_err,
  input  logic                          i_clr_err
);

  localparam int unsigned LIMIT_2400  = TIMEOUT_BITS * bit_period_cycles(BAUD_2400,  CLK_FREQ);
  localparam int unsigned LIMIT_4800  = TIMEOUT_BITS * bit_period_cycles(BAUD_4800,  CLK_FREQ);
  localparam int unsigned LIMIT_9600  = TIMEOUT_BITS * bit_period_cycles(BAUD_9600,  CLK_FREQ);
  localparam int unsigned LIMIT_19200 = TIMEOUT_BITS * bit_period_cycles(BAUD_19200, CLK_FREQ);
  // The slowest baud gives the longest timeout, so it sizes the timer.
  localparam int unsigned TIMER_W     = $clog2(LIMIT_2400 + 1);

  logic                 r_din_s1;
  logic                 r_din_s2;
  logic                 r_din_prev;
  logic [1:0]           r_sync_fill;
  logic                 r_flag_d;
  rx_state_t            r_state;
  rx_state_t            w_state_next;
  logic [TIMER_W-1:0]   r_timer;
  logic [TIMER_W-1:0]   w_timer_last;
  logic                 w_timer_clr;
  logic                 w_timeout_set;
  logic                 w_start;
  logic                 w_capture;
  logic                 w_cfg_apply;
  logic [1:0]           r_baud;
  logic [1:0]           r_parity;
  logic [1:0]           r_pend_baud;
  logic [1:0]           r_pend_parity;
  logic                 r_cfg_pending;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_pop;
  logic                 w_perr;
  logic [8:0]           w_head;
  logic                 w_overflow_set;
  logic                 r_overflow;
  logic                 r_timeout_err;

  // Line synchroniser. r_sync_fill marks when r_din_s2 holds a real sample
  // rather than its reset value; r_din_prev stays 0 until then, so a line
  // that is already low when reset releases never looks like a falling edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_din_s1    <= 1'b1;
      r_din_s2    <= 1'b1;
      r_din_prev  <= 1'b0;
      r_sync_fill <= 2'b00;
      r_flag_d    <= 1'b0;
    end else begin
      r_din_s1    <= i_din;
      r_din_s2    <= r_din_s1;
      r_din_prev  <= r_sync_fill[1] & r_din_s2;
      r_sync_fill <= {r_sync_fill[0], 1'b1};
      r_flag_d    <= i_uart_recieve_flag;
    end
  end

  assign w_start   = r_sync_fill[1] & r_din_prev & ~r_din_s2;
  // Rising edge only, so a level-style done flag yields one capture.
  assign w_capture = i_uart_recieve_flag & ~r_flag_d;

  always_comb begin
    w_timer_last = '0;
    case (r_baud)
      BAUD_2400: w_timer_last = TIMER_W'(LIMIT_2400  - 1);
      BAUD_4800: w_timer_last = TIMER_W'(LIMIT_4800  - 1);
      BAUD_9600: w_timer_last = TIMER_W'(LIMIT_9600  - 1);
      default:   w_timer_last = TIMER_W'(LIMIT_19200 - 1);
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_timer_clr   = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next = ST_FRAME;
          w_timer_clr  = 1'b1;
        end
      end
      ST_FRAME: begin
        // A byte arriving on the last timer cycle completes the frame.
        if (w_capture) begin
          w_state_next = ST_STOP_WAIT;
        end else if (r_timer == w_timer_last) begin
          w_timeout_set = 1'b1;
          w_state_next  = ST_STOP_WAIT;
        end
      end
      ST_STOP_WAIT: begin
        if (r_din_s2) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_timer <= '0;
    end else if (w_timer_clr) begin
      r_timer <= '0;
    end else if (r_state == ST_FRAME) begin
      r_timer <= r_timer + TIMER_W'(1);
    end
  end

  // Configuration only changes in an idle cycle that is not starting a frame,
  // so a frame always runs with the settings it started under.
  assign w_cfg_apply = r_cfg_pending & (r_state == ST_IDLE) & ~w_start;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_baud        <= RESET_BAUD;
      r_parity      <= RESET_PARITY;
      r_pend_baud   <= RESET_BAUD;
      r_pend_parity <= RESET_PARITY;
      r_cfg_pending <= 1'b0;
    end else begin
      if (w_cfg_apply) begin
        r_baud   <= r_pend_baud;
        r_parity <= r_pend_parity;
      end
      // A write in the same cycle as an apply stays pending for the next one.
      if (i_cfg_wr) begin
        r_pend_baud   <= i_cfg_baud_rate;
        r_pend_parity <= i_cfg_parity_type;
        r_cfg_pending <= 1'b1;
      end else if (w_cfg_apply) begin
        r_cfg_pending <= 1'b0;
      end
    end
  end

  assign w_perr         = parity_error(r_parity, i_uart_out, i_uart_parity_bit);
  assign w_pop          = o_m_valid & i_m_ready;
  assign w_overflow_set = w_capture & w_fifo_full & ~w_pop;

  uart_rx_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_capture),
    .i_data  ({w_perr, i_uart_out}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (o_fifo_count)
  );

  // Set has priority over clear on both sticky flags.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_overflow_set) begin
        r_overflow <= 1'b1;
      end else if (i_clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_timeout_set) begin
        r_timeout_err <= 1'b1;
      end else if (i_clr_err) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign o_baud_rate   = r_baud;
  assign o_parity_type = r_parity;
  assign o_cfg_pending = r_cfg_pending;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_m_data      = w_head[7:0];
  assign o_m_perr      = w_head[8];
  assign o_m_valid     = ~w_fifo_empty;
  assign o_overflow    = r_overflow;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  localparam int TIMEOUT_19200 = 31248;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_baud = 2'b11;
  logic [1:0] cfg_par = 2'b10;
  logic       din = 1'b1;
  logic       flag = 1'b0;
  logic [7:0] uart_out = 8'h00;
  logic       pbit = 1'b0;
  logic [1:0] baud_rate;
  logic [1:0] parity_type;
  logic       cfg_pending;
  logic       busy;
  logic [7:0] m_data;
  logic       m_perr;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       timeout_err;
  logic       clr_err = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] par;
    logic [7:0] data;
    logic       pb;
    logic       exp_perr;
  } pvec_t;

  pvec_t tbl [8];

  logic [8:0] q [$];
  logic [1:0] m_baud;
  logic [1:0] m_par;
  logic       m_ovf;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .i_clk               (clk),
    .i_reset             (reset),
    .i_cfg_wr            (cfg_wr),
    .i_cfg_baud_rate     (cfg_baud),
    .i_cfg_parity_type   (cfg_par),
    .i_din               (din),
    .i_uart_recieve_flag (flag),
    .i_uart_out          (uart_out),
    .i_uart_parity_bit   (pbit),
    .o_baud_rate         (baud_rate),
    .o_parity_type       (parity_type),
    .o_cfg_pending       (cfg_pending),
    .o_busy              (busy),
    .o_m_data            (m_data),
    .o_m_perr            (m_perr),
    .o_m_valid           (m_valid),
    .i_m_ready           (m_ready),
    .o_fifo_count        (fifo_count),
    .o_overflow          (overflow),
    .o_timeout_err       (timeout_err),
    .i_clr_err           (clr_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] b, input logic [1:0] p);
    cfg_wr = 1'b1;
    cfg_baud = b;
    cfg_par = p;
    tick();
    cfg_wr = 1'b0;
  endtask

  // One frame: line low, byte-done flag (pulse or held level), line high, settle.
  task automatic frame(input logic [7:0] d, input logic p, input logic rdy,
                       input logic clr, input int hold);
    din = 1'b0;
    repeat (5) tick();
    uart_out = d;
    pbit = p;
    flag = 1'b1;
    m_ready = rdy;
    clr_err = clr;
    tick();
    m_ready = 1'b0;
    clr_err = 1'b0;
    repeat (hold) tick();
    flag = 1'b0;
    din = 1'b1;
    repeat (5) tick();
  endtask

  task automatic pop_chk(input string name, input logic [7:0] d, input logic p);
    check({name, " valid"}, m_valid, 1'b1);
    check({name, " data"}, m_data, d);
    check({name, " perr"}, m_perr, p);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 20; k++) begin
      if (!busy) break;
      tick();
    end
    check({name, " idle"}, busy, 1'b0);
  endtask

  // Reference parity rule: even parity means the byte plus its parity bit hold
  // an even number of ones; odd parity means an odd number.
  function automatic logic ref_perr(input logic [1:0] par, input logic [7:0] d, input logic p);
    int ones;
    ones = $countones(d) + int'(p);
    if (par == 2'b10) return (ones % 2) != 0;
    if (par == 2'b01) return (ones % 2) != 1;
    return 1'b0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'b10, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{2'b10, 8'h01, 1'b0, 1'b1};
    tbl[2] = '{2'b01, 8'h01, 1'b0, 1'b0};
    tbl[3] = '{2'b01, 8'hA5, 1'b0, 1'b1};
    tbl[4] = '{2'b00, 8'h01, 1'b1, 1'b0};
    tbl[5] = '{2'b11, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{2'b10, 8'hFF, 1'b1, 1'b1};
    tbl[7] = '{2'b01, 8'h7F, 1'b0, 1'b0};

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();
    check("rst baud", baud_rate, 2'b11);
    check("rst parity", parity_type, 2'b10);
    check("rst busy", busy, 1'b0);
    check("rst valid", m_valid, 1'b0);
    check("rst count", fifo_count, 3'd0);
    check("rst pending", cfg_pending, 1'b0);
    check("rst overflow", overflow, 1'b0);
    check("rst timeout", timeout_err, 1'b0);

    frame(8'hA5, 1'b0, 1'b0, 1'b0, 0);
    pop_chk("a5", 8'hA5, 1'b0);
    check("a5 empty", m_valid, 1'b0);

    for (int i = 0; i < 8; i++) begin
      cfg(2'b11, tbl[i].par);
      tick();
      check($sformatf("tbl%0d parity", i), parity_type, tbl[i].par);
      frame(tbl[i].data, tbl[i].pb, 1'b0, 1'b0, 0);
      pop_chk($sformatf("tbl%0d", i), tbl[i].data, tbl[i].exp_perr);
      check($sformatf("tbl%0d empty", i), m_valid, 1'b0);
    end

    // Configuration written mid-frame waits for IDLE.
    cfg(2'b11, 2'b10);
    tick();
    din = 1'b0;
    repeat (5) tick();
    check("midcfg busy", busy, 1'b1);
    cfg(2'b00, 2'b10);
    check("midcfg baud frame", baud_rate, 2'b11);
    check("midcfg pending frame", cfg_pending, 1'b1);
    uart_out = 8'h3C;
    pbit = 1'b0;
    flag = 1'b1;
    tick();
    flag = 1'b0;
    check("midcfg baud stop", baud_rate, 2'b11);
    din = 1'b1;
    wait_idle("midcfg");
    check("midcfg baud at idle", baud_rate, 2'b11);
    check("midcfg pending at idle", cfg_pending, 1'b1);
    tick();
    check("midcfg baud applied", baud_rate, 2'b00);
    check("midcfg pending clr", cfg_pending, 1'b0);
    pop_chk("midcfg", 8'h3C, 1'b0);
    cfg(2'b11, 2'b10);
    check("idlecfg baud before", baud_rate, 2'b00);
    tick();
    check("idlecfg baud after", baud_rate, 2'b11);

    // Overflow; the fifth byte coincides with clr_err and the set wins.
    frame(8'h11, 1'b0, 1'b0, 1'b0, 0);
    frame(8'h22, 1'b0, 1'b0, 1'b0, 0);
    frame(8'h33, 1'b0, 1'b0, 1'b0, 0);
    frame(8'h44, 1'b0, 1'b0, 1'b0, 0);
    check("ovf not yet", overflow, 1'b0);
    frame(8'h55, 1'b0, 1'b0, 1'b1, 0);
    check("ovf count", fifo_count, 3'd4);
    check("ovf flag", overflow, 1'b1);
    check("ovf head", m_data, 8'h11);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("ovf cleared", overflow, 1'b0);
    frame(8'h66, 1'b0, 1'b1, 1'b0, 0);
    check("full pushpop count", fifo_count, 3'd4);
    check("full pushpop ovf", overflow, 1'b0);
    pop_chk("drain22", 8'h22, 1'b0);
    pop_chk("drain33", 8'h33, 1'b0);
    pop_chk("drain44", 8'h44, 1'b0);
    pop_chk("drain66", 8'h66, 1'b0);
    check("drain count", fifo_count, 3'd0);

    // Frame timeout at 19200 baud.
    din = 1'b0;
    repeat (TIMEOUT_19200 - 6) tick();
    check("tmo early", timeout_err, 1'b0);
    check("tmo busy", busy, 1'b1);
    for (int k = 0; k < 12; k++) begin
      if (timeout_err) break;
      tick();
    end
    check("tmo set", timeout_err, 1'b1);
    check("tmo busy stop", busy, 1'b1);
    din = 1'b1;
    repeat (5) tick();
    check("tmo idle", busy, 1'b0);
    check("tmo sticky", timeout_err, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("tmo cleared", timeout_err, 1'b0);

    // Reset in mid-frame with the line still low.
    cfg(2'b01, 2'b01);
    tick();
    din = 1'b0;
    repeat (6) tick();
    check("rstmid busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    check("rstmid busy in reset", busy, 1'b0);
    reset = 1'b0;
    repeat (8) tick();
    check("rstmid no start", busy, 1'b0);
    check("rstmid baud", baud_rate, 2'b11);
    check("rstmid parity", parity_type, 2'b10);
    din = 1'b1;
    repeat (4) tick();

    // Randomised traffic against a queue model.
    m_baud = 2'b11;
    m_par = 2'b10;
    m_ovf = 1'b0;
    for (int it = 0; it < 40; it++) begin
      logic [7:0] d;
      logic       p;
      int         npop;
      if ($urandom_range(0, 3) == 0) begin
        m_baud = 2'($urandom_range(0, 3));
        m_par = 2'($urandom_range(0, 3));
        cfg(m_baud, m_par);
        tick();
        check($sformatf("rnd%0d baud", it), baud_rate, m_baud);
        check($sformatf("rnd%0d parity", it), parity_type, m_par);
      end
      d = 8'($urandom);
      p = 1'($urandom);
      frame(d, p, 1'b0, 1'b0, $urandom_range(0, 2));
      if (q.size() < 4) q.push_back({ref_perr(m_par, d, p), d});
      else m_ovf = 1'b1;
      check($sformatf("rnd%0d count", it), fifo_count, q.size());
      check($sformatf("rnd%0d overflow", it), overflow, m_ovf);
      npop = $urandom_range(0, 2);
      for (int j = 0; j < npop; j++) begin
        if (q.size() == 0) break;
        pop_chk($sformatf("rnd%0d pop%0d", it, j), q[0][7:0], q[0][8]);
        void'(q.pop_front());
      end
      check($sformatf("rnd%0d valid", it), m_valid, q.size() != 0);
      if ($urandom_range(0, 4) == 0) begin
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        m_ovf = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
